pia_riot: RTL and testbench

PIA_RIOT -- requirements
Module: pia_riot

---
 rtl/pia_riot_pkg.sv | 41 ++++
 rtl/pia_riot_timer.sv | 56 +++++
 rtl/pia_riot.sv | 141 ++++++++++++++
 tb/tb_pia_riot.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pia_riot_pkg.sv
// Purpose: shared constants for the PIA/RIOT block (register map, prescale codes, TIMINT bits).
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package pia_riot_pkg;

    // Register map
    localparam logic [6:0] ADR_INTIM      = 7'h04;
    localparam logic [6:0] ADR_TIMINT     = 7'h05;
    localparam logic [6:0] ADR_INTIM_HI   = 7'h06;
    localparam logic [6:0] ADR_EDGE_BASE  = 7'h04;
    localparam logic [6:0] ADR_EDGE_MASK  = 7'h7C;   // 0x04-0x07
    localparam logic [6:0] ADR_TIMER_BASE = 7'h14;
    localparam logic [6:0] ADR_TIMER_MASK = 7'h74;   // 0x14-0x17, 0x1C-0x1F
    localparam int         TIMER_IE_BIT   = 3;       // address bit enabling the timer IRQ

    // Prescale select encodings (address bits [1:0] of a timer write)
    localparam logic [1:0] PRESC_1    = 2'd0;
    localparam logic [1:0] PRESC_8    = 2'd1;
    localparam logic [1:0] PRESC_64   = 2'd2;
    localparam logic [1:0] PRESC_1024 = 2'd3;

    // TIMINT bit positions
    localparam int TIMINT_TIMER_BIT = 7;
    localparam int TIMINT_EDGE_BIT  = 6;

    // Terminal count of the prescaler: prescale - 1
    function automatic logic [9:0] presc_last(input logic [1:0] sel);
        case (sel)
            PRESC_1:  return 10'd0;
            PRESC_8:  return 10'd7;
            PRESC_64: return 10'd63;
            default:  return 10'd1023;
        endcase
    endfunction

    // Data register address of I/O port n; its DDR sits at the next address
    function automatic logic [6:0] port_base(input int n);
        return (n < 2) ? 7'(2 * n) : 7'(8 + 2 * (n - 2));
    endfunction

endpackage

// File: rtl/pia_riot_timer.sv
// Purpose: interval timer - prescaler, INTIM down-counter, underflow flag.
// Latency: load takes effect on the strobe edge; first decrement `prescale` cycles later.
// Backpressure: none; load and flag-clear are single-cycle pulses always accepted.
module pia_riot_timer
    import pia_riot_pkg::*;
#(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic [1:0]         load_sel,
    input  logic               clr_flag,
    output logic [TIMER_W-1:0] intim,
    output logic               flag
);

    logic [9:0] presc_cnt;
    logic [1:0] presc_sel;
    logic       fast;       // set on underflow: count every cycle until the next load
    logic       tick;
    logic       underflow;

    assign tick      = fast | (presc_cnt == presc_last(presc_sel));
    assign underflow = tick & (intim == '0);

    // Prescaler, counter and flag; a load overrides any same-cycle underflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= 10'd0;
            presc_sel <= PRESC_1024;
            fast      <= 1'b0;
            intim     <= '0;
            flag      <= 1'b0;
        end else if (load) begin
            presc_cnt <= 10'd0;
            presc_sel <= load_sel;
            fast      <= 1'b0;
            intim     <= load_val;
            flag      <= 1'b0;
        end else begin
            presc_cnt <= tick ? 10'd0 : presc_cnt + 10'd1;
            if (tick) begin
                intim <= intim - TIMER_W'(1);
            end
            if (underflow) begin
                fast <= 1'b1;
                flag <= 1'b1;
            end else if (clr_flag) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pia_riot.sv
// Purpose: PIA/RIOT-style I/O ports, interval timer and optional PA7 edge detector (PIA_RIOT_EDGE_DET_EN).
// Latency: writes take effect on the strobe edge; dat_o is registered, valid one cycle after a read.
// Backpressure: none; every strobe is accepted in its cycle.
module pia_riot
    import pia_riot_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int TIMER_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [6:0]          adr_i,
    input  logic [7:0]          dat_i,
    output logic [7:0]          dat_o,
    output logic                irq_o,
    input  logic [8*NPORTS-1:0] port_i,
    output logic [8*NPORTS-1:0] port_o,
    output logic [8*NPORTS-1:0] port_dir_o
);

    logic               wr_en;
    logic               rd_en;
    logic               timer_load;
    logic               timer_ie;
    logic               timer_flag;
    logic [TIMER_W-1:0] intim;
    logic [15:0]        intim_ext;
    logic               edge_flag;
    logic               edge_ie;
    logic [7:0]         rd_dat;

    assign wr_en      = stb_i & we_i;
    assign rd_en      = stb_i & ~we_i;
    assign timer_load = wr_en & ((adr_i & ADR_TIMER_MASK) == ADR_TIMER_BASE);
    assign intim_ext  = 16'(intim);

    pia_riot_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (timer_load),
        .load_val (TIMER_W'(dat_i)),
        .load_sel (adr_i[1:0]),
        .clr_flag (rd_en & (adr_i == ADR_INTIM)),
        .intim    (intim),
        .flag     (timer_flag)
    );

    // Timer IRQ enable is re-latched by every timer load
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_ie <= 1'b0;
        end else if (timer_load) begin
            timer_ie <= adr_i[TIMER_IE_BIT];
        end
    end

    // Port data latches and direction registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            port_o     <= '0;
            port_dir_o <= '0;
        end else if (wr_en) begin
            for (int n = 0; n < NPORTS; n++) begin
                if (adr_i == port_base(n)) begin
                    port_o[8*n +: 8] <= dat_i;
                end
                if (adr_i == port_base(n) + 7'd1) begin
                    port_dir_o[8*n +: 8] <= dat_i;
                end
            end
        end
    end

`ifdef PIA_RIOT_EDGE_DET_EN
    logic pa7_q;
    logic edge_pol;     // 1 = rising edge, 0 = falling edge
    logic edge_hit;

    assign edge_hit = edge_pol ? (~pa7_q & port_i[7]) : (pa7_q & ~port_i[7]);

    // PA7 edge detector; a detected edge wins over a same-cycle TIMINT read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pa7_q     <= 1'b0;
            edge_pol  <= 1'b0;
            edge_ie   <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            pa7_q <= port_i[7];
            if (wr_en && ((adr_i & ADR_EDGE_MASK) == ADR_EDGE_BASE)) begin
                edge_pol <= adr_i[0];
                edge_ie  <= adr_i[1];
            end
            if (edge_hit) begin
                edge_flag <= 1'b1;
            end else if (rd_en && (adr_i == ADR_TIMINT)) begin
                edge_flag <= 1'b0;
            end
        end
    end
`else
    assign edge_flag = 1'b0;
    assign edge_ie   = 1'b0;
`endif

    // Read mux: pins show through where the DDR marks a bit as input
    always_comb begin
        rd_dat = 8'h00;
        case (adr_i)
            ADR_INTIM:    rd_dat = intim_ext[7:0];
            ADR_TIMINT: begin
                rd_dat[TIMINT_TIMER_BIT] = timer_flag;
                rd_dat[TIMINT_EDGE_BIT]  = edge_flag;
            end
            ADR_INTIM_HI: rd_dat = intim_ext[15:8];
            default:      rd_dat = 8'h00;
        endcase
        for (int n = 0; n < NPORTS; n++) begin
            if (adr_i == port_base(n)) begin
                rd_dat = (port_o[8*n +: 8] & port_dir_o[8*n +: 8]) |
                         (port_i[8*n +: 8] & ~port_dir_o[8*n +: 8]);
            end else if (adr_i == port_base(n) + 7'd1) begin
                rd_dat = port_dir_o[8*n +: 8];
            end
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_o <= 8'h00;
        end else if (rd_en) begin
            dat_o <= rd_dat;
        end
    end

    assign irq_o = (timer_flag & timer_ie) | (edge_flag & edge_ie);

endmodule

// File: tb/tb_pia_riot.sv
// Purpose: directed self-checking bench for pia_riot with a cycle-level behavioural model.
// Latency: model predicts register state after each clock edge; outputs compared 1 time unit later.
// Backpressure: n/a.
module tb_pia_riot;

    localparam int NP = 2;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [6:0]    adr = 7'h00;
    logic [7:0]    dat_i = 8'h00;
    logic [7:0]    dat_o;
    logic          irq;
    logic [8*NP-1:0] port_i = '0;
    logic [8*NP-1:0] port_o;
    logic [8*NP-1:0] port_dir;

    int checks = 0;
    int failures = 0;

    pia_riot #(.NPORTS(NP), .TIMER_W(TW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .stb_i      (stb),
        .we_i       (we),
        .adr_i      (adr),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .irq_o      (irq),
        .port_i     (port_i),
        .port_o     (port_o),
        .port_dir_o (port_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_port [NP];
    int m_ddr  [NP];
    int m_dat, mV, mP, mE, m_flag, m_ie, m_eflag, m_eie, m_pol, m_pa7;
    int ptab [4] = '{1, 8, 64, 1024};
    int s_a, s_d, s_pin7, s_hit, s_exp;
    bit s_rd, s_wr;

    // Decrements performed e cycles after a load: prescaled until the first
    // underflow, then one per cycle.
    function automatic int decs(input int e);
        if (e < (mV + 1) * mP) return e / mP;
        return mV + 1 + (e - (mV + 1) * mP);
    endfunction

    function automatic int m_intim(input int e);
        return (mV - decs(e)) & ((1 << TW) - 1);
    endfunction

    // True when the decrement at cycle e wrapped the counter through zero
    function automatic bit m_uf(input int e);
        int d;
        d = decs(e);
        if (e < 1 || d == decs(e - 1) || d < mV + 1) return 1'b0;
        return ((d - mV - 1) % (1 << TW)) == 0;
    endfunction

    function automatic int base(input int n);
        return (n < 2) ? 2 * n : 8 + 2 * (n - 2);
    endfunction

    function automatic int pin_byte(input int n);
        return int'(port_i[8*n +: 8]);
    endfunction

    function automatic int m_read(input int a);
        for (int n = 0; n < NP; n++) begin
            if (a == base(n)) return (m_port[n] & m_ddr[n]) | (pin_byte(n) & ~m_ddr[n] & 255);
            if (a == base(n) + 1) return m_ddr[n];
        end
        if (a == 4) return m_intim(mE) & 255;
        if (a == 5) return m_flag * 128 + m_eflag * 64;
        if (a == 6) return (m_intim(mE) >> 8) & 255;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NP; n++) begin
                m_port[n] = 0;
                m_ddr[n]  = 0;
            end
            m_dat = 0; mV = 0; mP = 1024; mE = 0; m_flag = 0; m_ie = 0;
            m_eflag = 0; m_eie = 0; m_pol = 0; m_pa7 = 0;
        end else begin
            s_a = int'(adr); s_d = int'(dat_i); s_pin7 = int'(port_i[7]);
            s_rd = stb && !we; s_wr = stb && we;
            if (s_rd) m_dat = m_read(s_a);
            if (s_wr && ((s_a >= 'h14 && s_a <= 'h17) || (s_a >= 'h1C && s_a <= 'h1F))) begin
                mV = s_d; mP = ptab[s_a % 4]; mE = 0; m_flag = 0;
                m_ie = (s_a >= 'h1C) ? 1 : 0;
            end else begin
                mE++;
                if (m_uf(mE)) m_flag = 1;
                else if (s_rd && s_a == 4) m_flag = 0;
            end
            for (int n = 0; n < NP; n++) begin
                if (s_wr && s_a == base(n)) m_port[n] = s_d;
                if (s_wr && s_a == base(n) + 1) m_ddr[n] = s_d;
            end
`ifdef PIA_RIOT_EDGE_DET_EN
            s_hit = m_pol ? (!m_pa7 && s_pin7) : (m_pa7 && !s_pin7);
            if (s_hit != 0) m_eflag = 1;
            else if (s_rd && s_a == 5) m_eflag = 0;
            if (s_wr && s_a >= 4 && s_a <= 7) begin
                m_pol = s_a & 1;
                m_eie = (s_a >> 1) & 1;
            end
            m_pa7 = s_pin7;
`endif
        end
        #1;
        if (rst_n) begin
            check("model dat_o", int'(dat_o), m_dat);
            s_exp = ((m_flag != 0 && m_ie != 0) || (m_eflag != 0 && m_eie != 0)) ? 1 : 0;
            check("model irq_o", int'(irq), s_exp);
            for (int n = 0; n < NP; n++) begin
                check("model port_o", int'(port_o[8*n +: 8]), m_port[n]);
                check("model port_dir_o", int'(port_dir[8*n +: 8]), m_ddr[n]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        stb = 1'b0;
    endtask

    initial begin
        #1;
        check("reset dat_o", int'(dat_o), 0);
        check("reset irq_o", int'(irq), 0);
        check("reset port_o", int'(port_o), 0);
        check("reset port_dir_o", int'(port_dir), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Port mux, both ports, plus DDR and unmapped reads
        wr(7'h01, 8'hF0);
        wr(7'h00, 8'hA5);
        port_i[7:0] = 8'h3C;
        rd(7'h00);
        check("port0 mux read", int'(dat_o), 'hAC);
        wr(7'h03, 8'h0F);
        wr(7'h02, 8'h5A);
        port_i[15:8] = 8'hC3;
        rd(7'h02);
        check("port1 mux read", int'(dat_o), 'hCA);
        rd(7'h08);
        check("unmapped read", int'(dat_o), 0);
        rd(7'h01);
        check("ddr0 read", int'(dat_o), 'hF0);

        // 64-prescale load of 3
        wr(7'h16, 8'h03);
        idle(63);
        rd(7'h04);
        check("intim before first decrement", int'(dat_o), 'h03);
        rd(7'h04);
        check("intim after 64 cycles", int'(dat_o), 'h02);
        idle(190);
        rd(7'h05);
        check("timint before underflow", int'(dat_o), 'h00);
        rd(7'h05);
        check("timint after underflow", int'(dat_o), 'h80);
        rd(7'h04);
        check("intim fast count 1", int'(dat_o), 'hFE);
        rd(7'h04);
        check("intim fast count 2", int'(dat_o), 'hFD);
        rd(7'h06);
        check("intim high byte", int'(dat_o), 'h00);

        // IRQ path
        wr(7'h1C, 8'h01);
        check("irq after load", int'(irq), 0);
        idle(1);
        check("irq 1 cycle after load", int'(irq), 0);
        idle(1);
        check("irq 2 cycles after load", int'(irq), 1);
        rd(7'h04);
        check("intim at irq", int'(dat_o), 'hFF);
        check("irq after intim read", int'(irq), 0);

        // Load in the underflow cycle wins
        wr(7'h14, 8'h02);
        idle(2);
        wr(7'h15, 8'h55);
        rd(7'h05);
        check("timint after load-vs-underflow", int'(dat_o), 'h00);
        rd(7'h04);
        check("intim after load-vs-underflow", int'(dat_o), 'h55);

        // PA7 rising edge
        wr(7'h07, 8'h00);
        port_i[7] = 1'b1;
        idle(1);
`ifdef PIA_RIOT_EDGE_DET_EN
        check("edge irq", int'(irq), 1);
        rd(7'h05);
        check("edge timint", int'(dat_o), 'h40);
`else
        check("edge irq disabled", int'(irq), 0);
        rd(7'h05);
        check("edge timint disabled", int'(dat_o), 'h00);
`endif
        check("irq after timint read", int'(irq), 0);
        rd(7'h05);
        check("timint cleared", int'(dat_o), 'h00);

        // Asynchronous reset mid-count
        wr(7'h1C, 8'h01);
        idle(2);
        check("irq before reset", int'(irq), 1);
        rd(7'h00);
        check("port0 read before reset", int'(dat_o), 'hAC);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset dat_o", int'(dat_o), 0);
        check("async reset irq_o", int'(irq), 0);
        check("async reset port_o", int'(port_o), 0);
        check("async reset port_dir_o", int'(port_dir), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timer restarts from 0 at prescale 1024
        idle(1023);
        rd(7'h05);
        check("timint before post-reset underflow", int'(dat_o), 'h00);
        rd(7'h05);
        check("timint post-reset underflow", int'(dat_o), 'h80);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
